// File: rtl/im_loader.sv
// im_loader: streams a big-endian byte program into the instruction memory.
// Optional IM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module im_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_CHECK
    } state_t;

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH:0]   idx;
    logic [ADDR_WIDTH:0]   last_idx;
    logic [1:0]            byte_cnt;
    logic [23:0]           shreg;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]            sum;
`endif

    logic start_zero;
    logic start_big;
    logic start_ok;
    logic xfer;

    assign start_zero = start && (word_count == '0);
    assign start_big  = start && (word_count > CAPACITY);
    assign start_ok   = start && !start_zero && !start_big;
    assign xfer       = in_valid && in_ready;

    // Load sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            last_idx <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    // A failed checksum keeps the core held in reset.
                    if (state == S_DONE) cpu_rst <= err;
                    if (start_zero) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else if (start_big) begin
                        state   <= S_IDLE;
                        err     <= 1'b1;
                        done    <= 1'b0;
                        cpu_rst <= 1'b1;
                    end else if (start_ok) begin
                        state    <= S_RECV;
                        idx      <= '0;
                        last_idx <= word_count - ONE;
                        byte_cnt <= '0;
                        err      <= 1'b0;
                        done     <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_rst  <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                        sum      <= sum + in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            im_we    <= 1'b1;
                            im_addr  <= idx[ADDR_WIDTH-1:0];
                            im_wdata <= {shreg, in_data};
                            in_ready <= 1'b0;
                            state    <= S_WRITE;
                        end else begin
                            shreg <= {shreg[15:0], in_data};
                        end
                    end
                end
                S_WRITE: begin
                    if (idx == last_idx) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        state    <= S_CHECK;
                        in_ready <= 1'b1;
`else
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
`endif
                    end else begin
                        idx      <= idx + ONE;
                        state    <= S_RECV;
                        in_ready <= 1'b1;
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= (in_data != sum);
                        state    <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized scoreboard bench for im_loader.
// Expected writes come from a byte-queue model of the program image.
module tb_im_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    im_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    logic [7:0]    stim_q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            last_we_cyc = -100;
    bit            gap_check = 1'b0;
    bit            zero_load = 1'b0;
    bit            done_prev = 1'b0;
    logic [AW-1:0] last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each write and checks timing.
    always @(negedge clk) begin
        cyc++;
        if (im_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         im_addr, im_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("im_addr", 32'(im_addr), 32'(e.addr));
                chk("im_wdata", im_wdata, e.data);
            end
            chk("in_ready_in_write", 32'(in_ready), 32'd0);
            if (gap_check && last_we_cyc >= 0)
                chk("we_spacing", cyc - last_we_cyc, 5);
            last_we_cyc = cyc;
            last_addr = im_addr;
        end
`ifndef IM_LOADER_CHECKSUM_EN
        if (done && !done_prev && !zero_load)
            chk("done_after_we", cyc - last_we_cyc, 1);
`endif
        done_prev = done;
    end

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        word_count = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_rand(input int nwords);
        stim_q.delete();
        for (int i = 0; i < nwords * 4; i++)
            stim_q.push_back(8'($urandom));
    endtask

    task automatic push_exp(input int wc);
        for (int w = 0; w < wc; w++) begin
            wr_t e;
            e.addr = w[AW-1:0];
            e.data = {stim_q[4*w], stim_q[4*w+1],
                      stim_q[4*w+2], stim_q[4*w+3]};
            exp_q.push_back(e);
        end
    endtask

    // mode 0: continuous valid, 1: toggling, 2: random
    task automatic stream(input int n, input int mode);
        int   i = 0;
        int   guard = 0;
        logic v;
        while (i < n && guard < n * 20 + 50) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data = stim_q[i];
            if (v && in_ready) i++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (i < n) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d bytes expected %0d", i, n);
        end
    endtask

    task automatic run_load(input int wc, input int mode, input bit bad);
        logic [7:0] s = '0;
        int         nb = wc * 4;
        int         n = 0;
        logic       exp_err = 1'b0;
        push_exp(wc);
        for (int i = 0; i < nb; i++) s = s + stim_q[i];
`ifdef IM_LOADER_CHECKSUM_EN
        if (wc > 0) begin
            stim_q.push_back(bad ? s + 8'd1 : s);
            nb++;
            exp_err = bad;
        end
`endif
        gap_check = (mode == 0);
        zero_load = (wc == 0);
        last_we_cyc = -100;
        start = 1'b1;
        word_count = wc[AW:0];
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(wc != 0));
        chk("err_after_start", 32'(err), 32'd0);
        chk("done_after_start", 32'(done), 32'(wc == 0));
        stream(nb, mode);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(done), 32'd1);
        chk("scoreboard_left", exp_q.size(), 0);
        chk("err_final", 32'(err), 32'(exp_err));
        @(negedge clk);
        chk("cpu_rst_after_done", 32'(cpu_rst), 32'(exp_err));
        chk("busy_when_done", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_addr", 32'(im_addr), 32'd0);
        chk("rst_im_wdata", im_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_load(2, 0, 1'b0);
        stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_load(2, 1, 1'b0);

        do_reset();
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        word_count = 11'd1025;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("big_err", 32'(err), 32'd1);
        chk("big_busy", 32'(busy), 32'd0);
        chk("big_in_ready", 32'(in_ready), 32'd0);
        chk("big_done", 32'(done), 32'd0);
        chk("big_cpu_rst", 32'(cpu_rst), 32'd1);
        fill_rand(1);
        run_load(1, 2, 1'b0);

        do_reset();
        rst = 1'b1;
        @(negedge clk);
        fill_rand(3);
        push_exp(3);
        gap_check = 1'b0;
        start = 1'b1;
        word_count = 11'd3;
        @(negedge clk);
        start = 1'b0;
        stream(6, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_im_addr", 32'(im_addr), 32'd0);
        chk("abort_words_written", 3 - exp_q.size(), 1);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        fill_rand(1);
        run_load(1, 0, 1'b0);

        run_load(0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int wc;
            wc = $urandom_range(1, 8);
            fill_rand(wc);
            run_load(wc, 2, 1'b0);
        end

        stim_q.delete();
        for (int i = 0; i < 4096; i++) stim_q.push_back(8'(i));
        run_load(1024, 0, 1'b0);
        chk("full_last_addr", 32'(last_addr), 32'h3FF);

`ifdef IM_LOADER_CHECKSUM_EN
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 1'b0);
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 1'b1);
        fill_rand(2);
        run_load(2, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
